watchdog: RTL and testbench

Software-liveness watchdog for the AM radio FPGA datapath. The control processor must pulse `heartbeat` periodically while the watchdog is enabled. If no heartbeat arrives within a configurable number of clock cycles, the block first raises `warning`, then latches `force_reset`. Downstream logic uses `force_reset` to mute the RF output and put the DDS and modulator into a safe state.

---
 rtl/radio_pkg.sv | 9 +
 rtl/watchdog.sv | 85 ++++++++
 tb/tb_watchdog.sv | 130 +++++++++++++
 3 files changed

// File: rtl/radio_pkg.sv
// Shared constants for the AM radio FPGA datapath.
package radio_pkg;

    localparam int unsigned CLK_HZ             = 125_000_000;
    localparam int unsigned WDT_TIMEOUT_CYCLES = 125_000_000;
    localparam int unsigned WDT_WARN_CYCLES    = 100_000_000;
    localparam int unsigned WDT_COUNT_W        = 32;

endpackage : radio_pkg

// File: rtl/watchdog.sv
// Software-liveness watchdog: counts idle cycles between heartbeats, warns, then latches a trip
// that only a disable or reset can clear.
module watchdog
    import radio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WDT_TIMEOUT_CYCLES,
    parameter int unsigned WARN_CYCLES    = WDT_WARN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   heartbeat,
    output logic                   force_reset,
    output logic                   warning,
    output logic [WDT_COUNT_W-1:0] count
);

    localparam logic [WDT_COUNT_W-1:0] TIMEOUT_C = WDT_COUNT_W'(TIMEOUT_CYCLES);
    localparam logic [WDT_COUNT_W-1:0] WARN_C    = WDT_COUNT_W'(WARN_CYCLES);

    if ((WARN_CYCLES < 1) || (WARN_CYCLES >= TIMEOUT_CYCLES) || (TIMEOUT_CYCLES < 2))
    begin : g_bad_params
        $error("watchdog: require 1 <= WARN_CYCLES < TIMEOUT_CYCLES and TIMEOUT_CYCLES >= 2");
    end

    logic [WDT_COUNT_W-1:0] counter;
    logic                   triggered;
    logic [WDT_COUNT_W-1:0] inc_c;
    logic                   trip_c;
    logic                   warn_c;

    // Saturating increment; re-reaching the timeout while saturated is harmless since the trip is sticky.
    always_comb begin
        inc_c  = (counter == TIMEOUT_C) ? counter : counter + WDT_COUNT_W'(1);
        trip_c = (inc_c == TIMEOUT_C);
        warn_c = (inc_c >= WARN_C) && !trip_c && !triggered;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter   <= '0;
            triggered <= 1'b0;
            warning   <= 1'b0;
        end else if (!enable) begin
            counter   <= '0;
            triggered <= 1'b0;
            warning   <= 1'b0;
        end else if (heartbeat) begin
            counter   <= '0;
            warning   <= 1'b0;
        end else begin
            counter   <= inc_c;
            warning   <= warn_c;
            if (trip_c) begin
                triggered <= 1'b1;
            end
        end
    end

    assign force_reset = triggered;
    assign count       = counter;

`ifdef FORMAL
    logic f_past_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_past_valid <= 1'b0;
        end else begin
            f_past_valid <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            a_exclusive : assert (!(warning && force_reset));
            a_bounded   : assert (count <= TIMEOUT_C);
            if (f_past_valid && $past(rstn) && $past(enable) && enable) begin
                a_sticky : assert (!($past(force_reset) && !force_reset));
            end
        end
    end
`endif

endmodule : watchdog

// File: tb/tb_watchdog.sv
// Directed bench for watchdog with TIMEOUT_CYCLES=8, WARN_CYCLES=5.
module tb_watchdog;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        heartbeat;
    logic        force_reset;
    logic        warning;
    logic [31:0] count;

    int n_checks;
    int n_errors;

    watchdog #(
        .TIMEOUT_CYCLES(8),
        .WARN_CYCLES   (5)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .force_reset(force_reset),
        .warning    (warning),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int c, input bit w, input bit f);
        check({tag, ".count"}, count, 32'(c));
        check({tag, ".warning"}, {31'd0, warning}, {31'd0, w});
        check({tag, ".force_reset"}, {31'd0, force_reset}, {31'd0, f});
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        enable    = 1'b1;
        heartbeat = 1'b0;

        // Reset held for one edge
        tick();
        expect_all("reset", 0, 1'b0, 1'b0);
        rstn = 1'b1;

        // Warn then trip: warning on counts 5..7, trip at 8
        tick(); expect_all("run1", 1, 1'b0, 1'b0);
        tick(); expect_all("run2", 2, 1'b0, 1'b0);
        tick(); expect_all("run3", 3, 1'b0, 1'b0);
        tick(); expect_all("run4", 4, 1'b0, 1'b0);
        tick(); expect_all("run5", 5, 1'b1, 1'b0);
        tick(); expect_all("run6", 6, 1'b1, 1'b0);
        tick(); expect_all("run7", 7, 1'b1, 1'b0);
        tick(); expect_all("run8", 8, 1'b0, 1'b1);
        tick(); expect_all("sat9", 8, 1'b0, 1'b1);
        tick(); expect_all("sat10", 8, 1'b0, 1'b1);

        // Sticky trip through heartbeat; no warning while tripped
        heartbeat = 1'b1;
        tick(); expect_all("sticky_hb", 0, 1'b0, 1'b1);
        heartbeat = 1'b0;
        tick(); expect_all("sticky1", 1, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        expect_all("sticky5", 5, 1'b0, 1'b1);
        tick(); expect_all("sticky6", 6, 1'b0, 1'b1);
        enable = 1'b0;
        tick(); expect_all("disable", 0, 1'b0, 1'b0);
        enable = 1'b1;

        // Kick at count 6 while warning
        tick(); tick(); tick(); tick(); tick();
        expect_all("pre_kick5", 5, 1'b1, 1'b0);
        tick(); expect_all("pre_kick6", 6, 1'b1, 1'b0);
        heartbeat = 1'b1;
        tick(); expect_all("kick", 0, 1'b0, 1'b0);
        tick(); expect_all("hold_hb1", 0, 1'b0, 1'b0);
        tick(); expect_all("hold_hb2", 0, 1'b0, 1'b0);
        heartbeat = 1'b0;
        tick(); expect_all("resume1", 1, 1'b0, 1'b0);

        // Priority: disable with heartbeat while tripped clears the trip
        tick(); tick(); tick(); tick(); tick(); tick();
        expect_all("pre_trip7", 7, 1'b1, 1'b0);
        tick(); expect_all("trip2", 8, 1'b0, 1'b1);
        enable    = 1'b0;
        heartbeat = 1'b1;
        tick(); expect_all("priority", 0, 1'b0, 1'b0);
        enable    = 1'b1;
        heartbeat = 1'b0;
        tick(); expect_all("post_prio", 1, 1'b0, 1'b0);

        // Mid-run asynchronous reset at count 4
        rstn = 1'b0;
        tick(); expect_all("rst2", 0, 1'b0, 1'b0);
        rstn = 1'b1;
        tick(); tick(); tick(); tick();
        expect_all("mid4", 4, 1'b0, 1'b0);
        rstn      = 1'b0;
        heartbeat = 1'b1;
        enable    = 1'b0;
        #1;
        expect_all("async_clr", 0, 1'b0, 1'b0);
        tick(); expect_all("in_rst", 0, 1'b0, 1'b0);
        rstn      = 1'b1;
        heartbeat = 1'b0;
        enable    = 1'b1;
        tick(); expect_all("restart1", 1, 1'b0, 1'b0);
        tick(); expect_all("restart2", 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_watchdog
